key_scan: RTL and testbench
===========================

# key_scan

Matrix keypad scanner: the input-side counterpart of the multiplexed 7-segment display driver.
- Drives one keypad row low per `clk_div` tick and samples the active-low columns through a 2-flop synchronizer.
- Assembles one full-matrix snapshot per frame and debounces it over several consecutive frames.
- Emits a one-cycle `key_valid` strobe with the key code when a single key is held, and a `key_release` strobe when it is let go.
- Sits beside the display scanner on the same divided scan clock and feeds key codes to the display/control logic.

## Interface
- `ROWS`, 4, number of keypad rows driven.
- `COLS`, 4, number of keypad columns sensed.
- `DEBOUNCE`, 8, consecutive qualifying frames required to accept a press or a release (legal range 1..255).
- `clk_div`  input  1  scan clock (1 kHz nominal); the only clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `col_n`  input  `COLS`  column sense lines, active-low, externally pulled up, asynchronous to `clk_div`.
- `row_n`  output  `ROWS`  row drive, active-low one-hot, registered.
- `key_code`  output  `$clog2(ROWS*COLS)`  code of the accepted key, = row*COLS + col; holds until the next accepted press.
- `key_valid`  output  1  one-cycle strobe on press acceptance.
- `key_down`  output  1  level, high from press acceptance until release acceptance.
- `key_release`  output  1  one-cycle strobe on release acceptance.

## Operation
- Scan: `row_ptr` counts 0..ROWS-1 and wraps. Every edge, `row_n <= ~(1 << row_ptr)`, so exactly one row is low at a time.
- Sampling: `col_n` passes through a 2-flop synchronizer.
  - `row_ptr` is delayed through a matching 2-stage pipeline with a valid bit, so each synchronized sample is tagged with the row that produced it.
  - Samples with valid=0 are discarded.
- Frame accumulation:
  - Pressed bits (`~col_sync`) are ORed into a ROWS×COLS snapshot at the tagged row.
  - When the tagged row is ROWS-1, the snapshot is classified and then cleared:
    - NONE: no bits set.
    - SINGLE(k): exactly one bit set; k is its code.
    - MULTI: two or more bits set.
  - The classification produces a one-cycle `frame_done`.
- Debounce FSM advances only on `frame_done`; `cnt` is 8 bits.
  - IDLE:
    - SINGLE(k) → CAND, with cand=k and cnt=1.
    - If DEBOUNCE==1, go straight to PRESSED with acceptance.
  - CAND:
    - SINGLE(cand) → cnt+1. When cnt reaches DEBOUNCE → PRESSED, with `key_code`=cand, `key_valid` pulse, `key_down`=1.
    - NONE, MULTI, or SINGLE(other) → IDLE, cnt=0.
  - PRESSED:
    - Any frame with cand's bit set (even MULTI) → stay.
    - Otherwise → RELEASE, cnt=1. If DEBOUNCE==1, go straight to release acceptance.
  - RELEASE:
    - cand's bit clear → cnt+1. When cnt reaches DEBOUNCE → IDLE, with `key_down`=0 and a `key_release` pulse.
    - cand's bit set → PRESSED, cnt=0.
- Ghosting and rollover: MULTI never produces a press. A second key added during PRESSED generates no new strobe.
- The release strobe and a new candidate never occur on the same frame. The FSM returns to IDLE first, so a new press needs a fresh DEBOUNCE run.

## Timing
- Reset values:
  - `row_n`=all ones, `key_code`=0, `key_valid`=0, `key_down`=0, `key_release`=0.
  - `row_ptr`=0, sample-pipeline valid bits=0, snapshot=0, state=IDLE, cnt=0.
- First edge after reset release: `row_n`=~1 (row 0 low).
- A sample is available 2 edges after its row was driven. The first valid sample therefore arrives 3 edges after reset release.
- Frame period: ROWS edges. The first frame evaluated is the first one whose row-0 sample is valid.
- FSM outputs are registered:
  - `key_valid`, `key_down` and `key_release` change on the edge after the DEBOUNCE-th qualifying `frame_done`.
  - Strobes last exactly one `clk_div` cycle.
- Press-to-`key_valid` latency with a clean, stable press: DEBOUNCE×ROWS + at most ROWS+3 edges.
- Reset mid-operation: all outputs clear immediately (asynchronous), with no `key_release` pulse. After reset, a key still held is re-acquired through a full debounce.

## Structure
- Package `key_scan_pkg` holds:
  - `ks_state_t`, an enum of KS_IDLE, KS_CAND, KS_PRESSED, KS_RELEASE.
  - `frame_kind_t`, an enum of FR_NONE, FR_SINGLE, FR_MULTI.
  - Width constants derived from ROWS and COLS.
- One sub-module, `key_col_sync`: a parameterized-width 2-flop synchronizer with async active-low reset to all ones (idle, unpressed).
- Row scan, frame accumulation and the FSM stay in `key_scan`.

## Test plan
All scenarios use the default ROWS=4, COLS=4, DEBOUNCE=8. The bench models the keypad combinationally: `col_n[c]`=0 iff row r is low and key (r,c) is pressed.
- Reset, then no keys: `row_n` is 4'hF during reset, then walks E,D,B,7,E… every edge. All other outputs stay 0 indefinitely.
- Hold key (1,2):
  - Exactly one `key_valid` with `key_code`=6, and `key_down`=1, within 8×4+7 edges.
  - On release, `key_down` falls and a single `key_release` pulse appears after 8 clear frames.
- Bounce: key 6 pressed for 3 frames, released 1 frame, pressed again. No `key_valid` until 8 consecutive frames after the re-press.
- Ghost/rollover:
  - Keys 0 and 5 pressed together from IDLE: never valid.
  - Key 6 accepted, then key 9 added: no new strobe, `key_down` stays 1.
  - Key 6 then released with 9 held: `key_release` fires, and key 9 is accepted 8 frames later.
- Reset asserted while `key_down`=1: outputs are 0 immediately with no `key_release`. After deassertion with the key held, `key_valid` reappears after a full debounce.
- DEBOUNCE=1 build: a single clean frame of key 15 gives `key_valid` with `key_code`=15. One clear frame gives `key_release`.

Source files
------------

// File: rtl/key_scan_pkg.sv
// Shared types and default geometry for the matrix keypad scanner.
// Imported by the scanner top and its column synchronizer.
package key_scan_pkg;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_CAND,
        KS_PRESSED,
        KS_RELEASE
    } ks_state_t;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_SINGLE,
        FR_MULTI
    } frame_kind_t;

    localparam int KS_ROWS   = 4;
    localparam int KS_COLS   = 4;
    localparam int KS_KEYS   = KS_ROWS * KS_COLS;
    localparam int KS_CODE_W = $clog2(KS_KEYS);
    localparam int KS_CNT_W  = 8;

    // A single-row keypad still needs a one-bit row pointer.
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_scan_col_sync.sv
// Two-flop synchronizer for the asynchronous active-low column sense lines.
// Resets to all ones so the keypad reads as fully released.
module key_col_sync
    import key_scan_pkg::*;
#(
    parameter int WIDTH = KS_COLS
) (
    input  logic             clk_div,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
        end
    end

    assign dout_o = sync_q;

endmodule

// File: rtl/key_scan.sv
// Matrix keypad scanner: walks one low row per tick, builds a per-frame snapshot
// of pressed keys, and debounces single-key presses and releases over whole frames.
module key_scan
    import key_scan_pkg::*;
#(
    parameter int ROWS     = KS_ROWS,
    parameter int COLS     = KS_COLS,
    parameter int DEBOUNCE = 8
) (
    input  logic                          clk_div,
    input  logic                          rst_n,
    input  logic [COLS-1:0]               col_n,
    output logic [ROWS-1:0]               row_n,
    output logic [$clog2(ROWS*COLS)-1:0]  key_code,
    output logic                          key_valid,
    output logic                          key_down,
    output logic                          key_release
);

    localparam int KEYS   = ROWS * COLS;
    localparam int CODE_W = $clog2(KEYS);
    localparam int PTR_W  = ptrWidth(ROWS);
    localparam logic [KS_CNT_W-1:0] DEB = KS_CNT_W'(DEBOUNCE);

    logic [PTR_W-1:0]    rowPtr_q, rowPtr_d;
    logic [ROWS-1:0]     rowN_q;
    logic [PTR_W-1:0]    rowDrv_q, pipeRow_q, tagRow_q;
    logic                drvValid_q, pipeValid_q, tagValid_q;
    logic [COLS-1:0]     colSync;
    logic [KEYS-1:0]     snap_q, snap_d;
    logic                frameEnd;
    logic                frameDone_q;
    logic [KEYS-1:0]     frameBits_q;
    frame_kind_t         frameKind;
    logic [CODE_W-1:0]   frameCode;
    logic [1:0]          bitCount;
    logic                candHeld;

    ks_state_t           state_q;
    logic [KS_CNT_W-1:0] cnt_q;
    logic [CODE_W-1:0]   cand_q;
    logic [CODE_W-1:0]   keyCode_q;
    logic                valid_q, down_q, release_q;

    key_col_sync #(.WIDTH(COLS)) u_col_sync (
        .clk_div (clk_div),
        .rst_n   (rst_n),
        .din_i   (col_n),
        .dout_o  (colSync)
    );

    always_comb begin
        rowPtr_d = (rowPtr_q == PTR_W'(ROWS - 1)) ? '0 : rowPtr_q + PTR_W'(1);
    end

    // Merge the synchronized sample into the snapshot row it was tagged with.
    always_comb begin
        snap_d = snap_q;
        if (tagValid_q) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (tagRow_q == PTR_W'(r) && !colSync[c]) begin
                        snap_d[r*COLS + c] = 1'b1;
                    end
                end
            end
        end
        frameEnd = tagValid_q && (tagRow_q == PTR_W'(ROWS - 1));
    end

    // The row tag trails the drive by the synchronizer depth, so it names the row each sample saw.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            rowPtr_q    <= '0;
            rowN_q      <= '1;
            rowDrv_q    <= '0;
            drvValid_q  <= 1'b0;
            pipeRow_q   <= '0;
            pipeValid_q <= 1'b0;
            tagRow_q    <= '0;
            tagValid_q  <= 1'b0;
            snap_q      <= '0;
            frameDone_q <= 1'b0;
            frameBits_q <= '0;
        end else begin
            rowPtr_q    <= rowPtr_d;
            rowN_q      <= ~(ROWS'(1) << rowPtr_q);
            rowDrv_q    <= rowPtr_q;
            drvValid_q  <= 1'b1;
            pipeRow_q   <= rowDrv_q;
            pipeValid_q <= drvValid_q;
            tagRow_q    <= pipeRow_q;
            tagValid_q  <= pipeValid_q;
            frameDone_q <= frameEnd;
            if (frameEnd) begin
                frameBits_q <= snap_d;
                snap_q      <= '0;
            end else begin
                snap_q      <= snap_d;
            end
        end
    end

    always_comb begin
        bitCount  = 2'd0;
        frameCode = '0;
        for (int i = 0; i < KEYS; i++) begin
            if (frameBits_q[i]) begin
                if (bitCount == 2'd0) begin
                    frameCode = CODE_W'(i);
                end
                if (bitCount != 2'd2) begin
                    bitCount = bitCount + 2'd1;
                end
            end
        end
        case (bitCount)
            2'd0:    frameKind = FR_NONE;
            2'd1:    frameKind = FR_SINGLE;
            default: frameKind = FR_MULTI;
        endcase
        candHeld = frameBits_q[cand_q];
    end

    // Debounce: a press needs DEBOUNCE identical single-key frames, a release DEBOUNCE frames without it.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= KS_IDLE;
            cnt_q     <= '0;
            cand_q    <= '0;
            keyCode_q <= '0;
            valid_q   <= 1'b0;
            down_q    <= 1'b0;
            release_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            release_q <= 1'b0;
            if (frameDone_q) begin
                case (state_q)
                    KS_IDLE: begin
                        if (frameKind == FR_SINGLE) begin
                            cand_q <= frameCode;
                            if (DEB == KS_CNT_W'(1)) begin
                                state_q   <= KS_PRESSED;
                                cnt_q     <= '0;
                                keyCode_q <= frameCode;
                                valid_q   <= 1'b1;
                                down_q    <= 1'b1;
                            end else begin
                                state_q <= KS_CAND;
                                cnt_q   <= KS_CNT_W'(1);
                            end
                        end
                    end
                    KS_CAND: begin
                        if (frameKind == FR_SINGLE && frameCode == cand_q) begin
                            if (cnt_q + KS_CNT_W'(1) == DEB) begin
                                state_q   <= KS_PRESSED;
                                cnt_q     <= '0;
                                keyCode_q <= cand_q;
                                valid_q   <= 1'b1;
                                down_q    <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + KS_CNT_W'(1);
                            end
                        end else begin
                            state_q <= KS_IDLE;
                            cnt_q   <= '0;
                        end
                    end
                    KS_PRESSED: begin
                        if (!candHeld) begin
                            if (DEB == KS_CNT_W'(1)) begin
                                state_q   <= KS_IDLE;
                                cnt_q     <= '0;
                                down_q    <= 1'b0;
                                release_q <= 1'b1;
                            end else begin
                                state_q <= KS_RELEASE;
                                cnt_q   <= KS_CNT_W'(1);
                            end
                        end
                    end
                    KS_RELEASE: begin
                        if (candHeld) begin
                            state_q <= KS_PRESSED;
                            cnt_q   <= '0;
                        end else if (cnt_q + KS_CNT_W'(1) == DEB) begin
                            state_q   <= KS_IDLE;
                            cnt_q     <= '0;
                            down_q    <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + KS_CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= KS_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign row_n       = rowN_q;
    assign key_code    = keyCode_q;
    assign key_valid   = valid_q;
    assign key_down    = down_q;
    assign key_release = release_q;

endmodule

// File: tb/tb_key_scan.sv
// Scoreboard bench for key_scan: a DEBOUNCE=8 and a DEBOUNCE=1 instance share one
// keypad; a frame-level reference model predicts every press/release strobe and its edge.
module tb_key_scan;

    typedef struct {
        bit isPress;
        int code;
        int edgeNo;
    } event_t;

    logic        clk_div = 1'b0;
    logic        rst_n;
    logic [15:0] keys;

    logic [3:0] rowA, rowB, colA, colB, codeA, codeB;
    logic       validA, validB, downA, downB, relA, relB;

    int edgeCount = 0;
    int checks = 0;
    int passes = 0;
    int endReq = 0;
    int endAck = 0;

    event_t      qA[$];
    event_t      qB[$];
    logic [15:0] plan[$];

    int rdA, rdB, lastCodeA, lastCodeB, lastReq;
    bit expDownA, expDownB;

    always #5 clk_div = ~clk_div;

    // Keypad: a column reads low when its key sits on the currently low row.
    function automatic logic [3:0] keypad(input logic [3:0] rows, input logic [15:0] k);
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++)
                if (!rows[r] && k[r*4 + cc]) c[cc] = 1'b0;
        return c;
    endfunction

    assign colA = keypad(rowA, keys);
    assign colB = keypad(rowB, keys);

    key_scan #(.ROWS(4), .COLS(4), .DEBOUNCE(8)) dutA (
        .clk_div(clk_div), .rst_n(rst_n), .col_n(colA), .row_n(rowA),
        .key_code(codeA), .key_valid(validA), .key_down(downA), .key_release(relA)
    );

    key_scan #(.ROWS(4), .COLS(4), .DEBOUNCE(1)) dutB (
        .clk_div(clk_div), .rst_n(rst_n), .col_n(colB), .row_n(rowB),
        .key_code(codeB), .key_valid(validB), .key_down(downB), .key_release(relB)
    );

    always @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) edgeCount <= 0;
        else        edgeCount <= edgeCount + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeCount);
    endtask

    function automatic int lowestKey(input logic [15:0] bits);
        for (int i = 0; i < 16; i++) if (bits[i]) return i;
        return -1;
    endfunction

    // Frame-level model: frame f is classified at edge 7+4f and its outcome shows after edge 8+4f.
    function automatic void modelEvents(input int deb, input int d);
        int held, cand, run, rel, n, k;
        logic [15:0] bits;
        event_t ev;
        held = -1; cand = -1; run = 0; rel = 0;
        for (int f = 0; f < plan.size(); f++) begin
            bits = plan[f];
            n = $countones(bits);
            k = lowestKey(bits);
            ev.edgeNo = 8 + 4*f;
            if (held < 0) begin
                if (run > 0 && n == 1 && k == cand) run++;
                else if (run > 0) run = 0;
                else if (n == 1) begin cand = k; run = 1; end
                if (run > 0 && run >= deb) begin
                    ev.isPress = 1'b1; ev.code = k;
                    if (d == 0) qA.push_back(ev); else qB.push_back(ev);
                    held = k; run = 0;
                end
            end else begin
                if (bits[held]) rel = 0;
                else begin
                    rel++;
                    if (rel >= deb) begin
                        ev.isPress = 1'b0; ev.code = held;
                        if (d == 0) qA.push_back(ev); else qB.push_back(ev);
                        held = -1; rel = 0;
                    end
                end
            end
        end
    endfunction

    function automatic void addFrames(input logic [15:0] p, input int n);
        for (int i = 0; i < n; i++) plan.push_back(p);
    endfunction

    function automatic event_t getEv(input int d, input int i);
        if (d == 0) return qA[i];
        return qB[i];
    endfunction

    // One scoreboard consumer per DUT; rd is the pop index into its expected-event queue.
    task automatic monitorDut(input int d, inout int rd, inout bit expDown, inout int lastCode);
        string tag;
        int qsz, code, expRow;
        logic v, rl, dn;
        logic [3:0] row;
        event_t ev;
        tag  = (d == 0) ? "deb8" : "deb1";
        qsz  = (d == 0) ? qA.size() : qB.size();
        v    = (d == 0) ? validA : validB;
        rl   = (d == 0) ? relA   : relB;
        dn   = (d == 0) ? downA  : downB;
        code = (d == 0) ? int'(codeA) : int'(codeB);
        row  = (d == 0) ? rowA : rowB;
        while (rd < qsz && getEv(d, rd).edgeNo < edgeCount) begin
            checkOutput({tag, "_missedEventEdge"}, edgeCount, getEv(d, rd).edgeNo);
            rd++;
        end
        for (int s = 0; s < 2; s++) begin
            if ((s == 0 && v) || (s == 1 && rl)) begin
                if (rd >= qsz) checkOutput({tag, "_spuriousStrobeCount"}, rd + 1, qsz);
                else begin
                    ev = getEv(d, rd);
                    rd++;
                    checkOutput({tag, "_strobeIsPress"}, (s == 0) ? 1 : 0, int'(ev.isPress));
                    checkOutput({tag, "_strobeEdge"}, edgeCount, ev.edgeNo);
                    if (ev.isPress) begin
                        checkOutput({tag, "_pressCode"}, code, ev.code);
                        expDown = 1'b1;
                        lastCode = ev.code;
                    end else expDown = 1'b0;
                end
            end
        end
        checkOutput({tag, "_keyDown"}, int'(dn), int'(expDown));
        checkOutput({tag, "_keyCodeHold"}, code, lastCode);
        expRow = (edgeCount == 0) ? 15 : (15 & ~(1 << ((edgeCount - 1) % 4)));
        checkOutput({tag, "_rowWalk"}, int'(row), expRow);
    endtask

    initial begin
        lastReq = 0;
        forever begin
            @(negedge clk_div);
            if (!rst_n) begin
                rdA = 0; rdB = 0; expDownA = 1'b0; expDownB = 1'b0; lastCodeA = 0; lastCodeB = 0;
                checkOutput("reset_rowA", int'(rowA), 15);
                checkOutput("reset_rowB", int'(rowB), 15);
                checkOutput("reset_outsA", int'({codeA, validA, downA, relA}), 0);
                checkOutput("reset_outsB", int'({codeB, validB, downB, relB}), 0);
            end else begin
                monitorDut(0, rdA, expDownA, lastCodeA);
                monitorDut(1, rdB, expDownB, lastCodeB);
                if (endReq != lastReq) begin
                    lastReq = endReq;
                    checkOutput("deb8_allEventsSeen", rdA, qA.size());
                    checkOutput("deb1_allEventsSeen", rdB, qB.size());
                    endAck = lastReq;
                end
            end
        end
    end

    // Reset both DUTs, predict the plan's events, then present one key pattern per frame.
    task automatic applyStimulus();
        int n;
        #2 rst_n = 1'b0;
        qA.delete();
        qB.delete();
        modelEvents(8, 0);
        modelEvents(1, 1);
        repeat (2) @(negedge clk_div);
        #1 rst_n = 1'b1;
        n = plan.size();
        for (int f = 0; f < n; f++) begin
            while (edgeCount < 1 + 4*f) begin @(posedge clk_div); #1; end
            keys = plan[f];
        end
        while (edgeCount < 4*n + 4) begin @(posedge clk_div); #1; end
        endReq++;
        for (int i = 0; i < 4 && endAck != endReq; i++) @(posedge clk_div);
        plan.delete();
    endtask

    task automatic randomSession();
        int kind, len, a, b;
        for (int s = 0; s < 8; s++) begin
            kind = $urandom_range(0, 3);
            len  = $urandom_range(1, 12);
            a    = $urandom_range(0, 15);
            b    = (a + $urandom_range(1, 15)) % 16;
            case (kind)
                0:       addFrames(16'h0000, len);
                3:       addFrames(16'(1 << a) | 16'(1 << b), len);
                default: addFrames(16'(1 << a), len);
            endcase
        end
        applyStimulus();
    endtask

    initial begin
        rst_n = 1'b0;
        keys  = 16'h0000;

        addFrames(16'h0000, 6);
        applyStimulus();

        addFrames(16'h0040, 12); addFrames(16'h0000, 12);
        applyStimulus();

        addFrames(16'h0040, 3); addFrames(16'h0000, 1);
        addFrames(16'h0040, 10); addFrames(16'h0000, 10);
        applyStimulus();

        addFrames(16'h0021, 10); addFrames(16'h0000, 2);
        addFrames(16'h0040, 10); addFrames(16'h0240, 5);
        addFrames(16'h0200, 20); addFrames(16'h0000, 10);
        applyStimulus();

        addFrames(16'h0000, 2); addFrames(16'h0040, 12);
        applyStimulus();

        addFrames(16'h0040, 12); addFrames(16'h0000, 10);
        applyStimulus();

        addFrames(16'h0000, 2); addFrames(16'h8000, 1); addFrames(16'h0000, 3);
        applyStimulus();

        for (int i = 0; i < 6; i++) randomSession();

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
